// File: rtl/rgb_sequencer_if.sv
// Handshake and colour-select bundle between a controlling harness and
// the RGB sequencer.
interface rgb_sequencer_if #(
    parameter int PWM_BITS = 4
);
    logic                start;
    logic                stop;
    logic                loop;
    logic [PWM_BITS-1:0] brightness;
    logic                a;
    logic                b;
    logic                c;
    logic [1:0]          step;
    logic                busy;
    logic                done;

    // The controlling side drives the requests and watches the status.
    modport master (
        output start, stop, loop, brightness,
        input  a, b, c, step, busy, done
    );

    // The sequencer consumes requests and drives the colour lines.
    modport slave (
        input  start, stop, loop, brightness,
        output a, b, c, step, busy, done
    );
endinterface

// File: rtl/rgb_sequencer.sv
// Steps the a/b/c colour-select lines through a fixed four-step pattern.
// Each step is held for DWELL_CYCLES clocks and active lines are
// PWM-gated by a brightness value captured when the sequence starts.
module rgb_sequencer #(
    parameter int DWELL_CYCLES = 10,
    parameter int PWM_BITS     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rgb_sequencer_if.slave    bus
);
    localparam int DW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_dwell_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic                r_loop;
    logic [1:0]          r_step;
    logic                r_a;
    logic                r_b;
    logic                r_c;
    logic                r_busy;
    logic                r_done;

    logic                w_dwell_last;
    logic                w_last_step;
    logic [1:0]          w_step_next;
    logic [PWM_BITS-1:0] w_pwm_next;
    logic                w_pwm_on;
    logic [2:0]          w_abc_next;

    // Fixed colour pattern {a,b,c} for each step index.
    function automatic logic [2:0] f_pattern(input logic [1:0] s);
        logic [2:0] v;
        case (s)
            2'd0:    v = 3'b000;
            2'd1:    v = 3'b001;
            2'd2:    v = 3'b010;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    // Next-cycle step and PWM phase; the outputs are registered from these
    // so a/b/c change on the same edge as step and pwm_cnt.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a value held, which would infer a latch.
        w_dwell_last = (r_dwell_cnt == DW'(DWELL_CYCLES - 1));
        w_last_step  = w_dwell_last && (r_step == 2'd3);
        w_step_next  = w_dwell_last ? r_step + 2'd1 : r_step;
        w_pwm_next   = r_pwm_cnt + PWM_BITS'(1);
        w_pwm_on     = (w_pwm_next < r_bright);
        w_abc_next   = f_pattern(w_step_next) & {3{w_pwm_on}};
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dwell_cnt <= '0;
            r_pwm_cnt   <= '0;
            r_bright    <= '0;
            r_loop      <= 1'b0;
            r_step      <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_c         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                    r_c    <= 1'b0;
                    r_step <= 2'd0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    // start with stop also high is refused.
                    if (bus.start && !bus.stop) begin
                        r_bright    <= bus.brightness;
                        r_loop      <= bus.loop;
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_dwell_cnt <= '0;
                        r_pwm_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        // Abort wins over any dwell expiry on this edge.
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                        r_step      <= 2'd0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_c         <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_pwm_cnt   <= '0;
                    end else if (w_last_step && !r_loop) begin
                        // Normal completion of a single pass.
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_step      <= 2'd0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_c         <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_pwm_cnt   <= '0;
                    end else begin
                        r_pwm_cnt   <= w_pwm_next;
                        r_dwell_cnt <= w_dwell_last ? '0 : r_dwell_cnt + DW'(1);
                        r_step      <= w_step_next;
                        {r_a, r_b, r_c} <= w_abc_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.a    = r_a;
    assign bus.b    = r_b;
    assign bus.c    = r_c;
    assign bus.step = r_step;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_rgb_sequencer.sv
// Directed bench for rgb_sequencer (DWELL_CYCLES=10, PWM_BITS=4).
// Time k counts edges after the edge that accepted start; after edge k
// the sequencer shows step k/10 and PWM phase k%16.
module tb_rgb_sequencer;
    localparam int DWELL = 10;
    localparam int PB    = 4;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   c_on;

    logic [2:0] pat [4];

    rgb_sequencer_if #(.PWM_BITS(PB)) bus ();

    rgb_sequencer #(
        .DWELL_CYCLES(DWELL),
        .PWM_BITS    (PB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start: the edge inside this task is k=0.
    task automatic do_start(input logic [PB-1:0] br, input logic lp);
        bus.start      = 1'b1;
        bus.stop       = 1'b0;
        bus.brightness = br;
        bus.loop       = lp;
        tick();
        bus.start = 1'b0;
    endtask

    // Check cycles k0..k1 of a running pass against the hand model, then tick.
    task automatic run_check(input string tag, input int k0, input int k1,
                             input logic [PB-1:0] br, input bit looped);
        int         s;
        logic [2:0] e;
        for (int k = k0; k <= k1; k++) begin
            s = looped ? (k / DWELL) % 4 : k / DWELL;
            e = (k == 0) ? 3'b000 : (((k % 16) < int'(br)) ? pat[s] : 3'b000);
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_step"}, 32'(bus.step), 32'(s));
            check({tag, "_abc"}, 32'({bus.a, bus.b, bus.c}), 32'(e));
            check({tag, "_done"}, 32'(bus.done), 32'd0);
            if (s == 1 && bus.c === 1'b1) c_on++;
            tick();
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_step"}, 32'(bus.step), 32'd0);
        check({tag, "_abc"}, 32'({bus.a, bus.b, bus.c}), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        c_on    = 0;
        pat[0] = 3'b000;
        pat[1] = 3'b001;
        pat[2] = 3'b010;
        pat[3] = 3'b100;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.loop       = 1'b0;
        bus.brightness = '0;
        rst_n = 1'b0;

        // Reset state.
        #12;
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset", 1'b0);

        // 1: single pass, full brightness.
        do_start(4'd15, 1'b0);
        run_check("t1", 0, 39, 4'd15, 1'b0);
        check_idle("t1_end", 1'b1);
        tick();
        check_idle("t1_after", 1'b0);

        // 2: brightness 4, c lit on 4 cycles of step 1.
        c_on = 0;
        do_start(4'd4, 1'b0);
        run_check("t2", 0, 39, 4'd4, 1'b0);
        check("t2_c_on", 32'(c_on), 32'd4);
        check_idle("t2_end", 1'b1);
        tick();

        // 3: looping for 120 cycles, then stop.
        do_start(4'd15, 1'b1);
        run_check("t3", 0, 119, 4'd15, 1'b1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("t3_stop", 1'b0);
        tick();
        check_idle("t3_stop2", 1'b0);

        // 4: stop on the same edge as last-step expiry.
        do_start(4'd15, 1'b0);
        run_check("t4", 0, 38, 4'd15, 1'b0);
        check("t4_k39_step", 32'(bus.step), 32'd3);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("t4_abort", 1'b0);
        tick();
        check_idle("t4_after", 1'b0);

        // 5: asynchronous reset in the middle of step 2.
        do_start(4'd15, 1'b0);
        run_check("t5", 0, 24, 4'd15, 1'b0);
        check("t5_pre_step", 32'(bus.step), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t5_async", 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check_idle("t5_released", 1'b0);
        do_start(4'd15, 1'b0);
        run_check("t5_restart", 0, 12, 4'd15, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_idle("t5_stop", 1'b0);

        // 6a: start and stop together in IDLE are refused.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        check_idle("t6_both", 1'b0);
        tick();
        check_idle("t6_both2", 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // 6b: brightness dropped mid-run has no effect until next start.
        do_start(4'd15, 1'b0);
        run_check("t6_pre", 0, 4, 4'd15, 1'b0);
        bus.brightness = 4'd0;
        bus.loop       = 1'b1;
        run_check("t6_post", 5, 39, 4'd15, 1'b0);
        check_idle("t6_end", 1'b1);
        tick();
        check_idle("t6_after", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
